// File: rtl/rgb_byte_serializer_pkg.sv
// Shared types for the RGB byte serializer: pixel record, channel order, FSM states.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
package rgb_byte_serializer_pkg;

  // One processed pixel, packed MSB-first so {r,g,b} matches the "%02x%02x%02x" record.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

  // Channel emission order within a pixel.
  localparam logic [1:0] BYTE_R = 2'd0;
  localparam logic [1:0] BYTE_G = 2'd1;
  localparam logic [1:0] BYTE_B = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_R = 2'd1,
    SEND_G = 2'd2,
    SEND_B = 2'd3
  } state_t;

  function automatic logic [7:0] pixel_byte(input pixel_t pix, input logic [1:0] sel);
    logic [7:0] res;
    res = 8'h00;
    case (sel)
      BYTE_R:  res = pix.r;
      BYTE_G:  res = pix.g;
      BYTE_B:  res = pix.b;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rgb_byte_serializer_pixel_fifo.sv
// Synchronous pixel FIFO, DEPTH entries of W bits, occupancy-count based full/empty.
// Latency: a pushed entry is visible on rd_data the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: clk, rst_n (sync, active-low), push/wr_data, pop/rd_data, full, empty, count.
module rgb_byte_serializer_pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/rgb_byte_serializer.sv
// Serializes 24-bit RGB pixels into an R,G,B byte stream, counting pixels and marking frame ends.
// Latency: pixel pushed into an empty FIFO at edge N -> R byte valid after edge N+1; 1 byte/cycle sustained.
// Backpressure: byte_ready low holds the current byte; pix_ready drops when the pixel FIFO is full.
// Ports: clk, rst_n (sync, active-low); pix_valid/pix_ready/r_in/g_in/b_in in;
//        byte_valid/byte_ready/byte_data/byte_last out; frame_done pulse; pix_count per frame.
module rgb_byte_serializer
  import rgb_byte_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH       = 4,
  parameter int PIXELS_PER_FRAME = 65536,
  parameter int CNT_W            = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  output logic             frame_done,
  output logic [CNT_W-1:0] pix_count
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(PIXELS_PER_FRAME - 1);
  localparam logic [FCW-1:0]   FIFO_CNT_MAX = FIFO_DEPTH[FCW-1:0];

  state_t           state;
  state_t           state_nxt;
  pixel_t           hold_pix;
  pixel_t           pix_in;
  pixel_t           fifo_rd_data;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [CNT_W-1:0] pix_count_q;
  logic             frame_done_q;
  logic             b_accept;

  assign pix_in = '{r: r_in, g: g_in, b: b_in};

  // Gated with rst_n so upstream sees no room while the FIFO is being cleared.
  assign pix_ready = rst_n && !fifo_full;
  assign fifo_push = pix_valid && pix_ready;

  rgb_byte_serializer_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIXEL_W)
  ) u_pixel_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (pix_in),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = SEND_R;
        end
      end
      SEND_R: begin
        byte_valid = 1'b1;
        byte_data  = pixel_byte(hold_pix, BYTE_R);
        if (byte_ready) state_nxt = SEND_G;
      end
      SEND_G: begin
        byte_valid = 1'b1;
        byte_data  = pixel_byte(hold_pix, BYTE_G);
        if (byte_ready) state_nxt = SEND_B;
      end
      SEND_B: begin
        byte_valid = 1'b1;
        byte_data  = pixel_byte(hold_pix, BYTE_B);
        byte_last  = (pix_count_q == LAST_IDX);
        // Chain straight into the next pixel so a full stream has no idle cycle.
        if (byte_ready) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = SEND_R;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign b_accept = (state == SEND_B) && byte_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_pix     <= '0;
      pix_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_q <= b_accept && byte_last;
      if (fifo_pop) hold_pix <= fifo_rd_data;
      if (b_accept) pix_count_q <= byte_last ? '0 : pix_count_q + 1'b1;
    end
  end

  assign pix_count  = pix_count_q;
  assign frame_done = frame_done_q;

  // The FIFO must never report more entries than it has slots.
  assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= FIFO_CNT_MAX);

endmodule

// File: tb/tb_rgb_byte_serializer.sv
module tb_rgb_byte_serializer;
  import rgb_byte_serializer_pkg::*;

  localparam int PPF = 3;

  logic        clk;
  logic        rst_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  r_in, g_in, b_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        frame_done;
  logic [16:0] pix_count;

  rgb_byte_serializer #(
    .FIFO_DEPTH       (4),
    .PIXELS_PER_FRAME (PPF),
    .CNT_W            (17)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .frame_done (frame_done),
    .pix_count  (pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard (runs at negedge) ----------------
  pixel_t      m_q[$];
  int          m_phase = 0;
  int          m_cnt = 0;
  logic        m_fd = 1'b0;
  bit          mon_en = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data;
  logic        prev_last;
  int          bytes_acc = 0;
  int          pix_acc = 0;
  int          fd_pulses = 0;
  int          last_cnt = 0;
  int          last_at = 0;
  int          cnt_log[$];

  function automatic logic [7:0] chan(input pixel_t p, input int ph);
    if (ph == 0) return p.r;
    if (ph == 1) return p.g;
    return p.b;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_last;
      chk("pix_count", 32'(pix_count), 32'(m_cnt));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      if (frame_done) fd_pulses++;
      if (m_q.size() == 0) chk("idle_valid", 32'(byte_valid), 32'd0);
      if (prev_stall) begin
        chk("stall_valid", 32'(byte_valid), 32'd1);
        chk("stall_data", 32'(byte_data), 32'(prev_data));
        chk("stall_last", 32'(byte_last), 32'(prev_last));
      end
      if (!rst_n) begin
        m_q.delete();
        m_phase    = 0;
        m_cnt      = 0;
        m_fd       = 1'b0;
        prev_stall = 0;
      end else begin
        m_fd = 1'b0;
        if (byte_valid && byte_ready) begin
          checks++;
          if (m_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_byte: got %0h expected no byte at %0t", byte_data, $time);
          end else begin
            exp_last = (m_phase == 2) && (m_cnt == PPF - 1);
            chk("byte_data", 32'(byte_data), 32'(chan(m_q[0], m_phase)));
            chk("byte_last", 32'(byte_last), 32'(exp_last));
            if (m_phase == 0) cnt_log.push_back(int'(pix_count));
            bytes_acc++;
            if (byte_last) begin
              last_cnt++;
              last_at = bytes_acc;
            end
            m_phase++;
            if (m_phase == 3) begin
              m_phase = 0;
              void'(m_q.pop_front());
              if (exp_last) begin
                m_cnt = 0;
                m_fd  = 1'b1;
              end else begin
                m_cnt++;
              end
            end
          end
        end
        if (pix_valid && pix_ready) begin
          m_q.push_back('{r: r_in, g: g_in, b: b_in});
          pix_acc++;
        end
        prev_stall = byte_valid && !byte_ready;
        prev_data  = byte_data;
        prev_last  = byte_last;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [23:0] p);
    logic acc;
    pix_valid = 1'b1;
    {r_in, g_in, b_in} = p;
    for (int t = 0; t < 200; t++) begin
      acc = pix_ready;
      tick();
      if (acc) begin
        pix_valid = 1'b0;
        return;
      end
    end
    pix_valid = 1'b0;
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      if (m_q.size() == 0 && !byte_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("drain_done", 32'(ok), 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rn;
    logic        pv;
    logic [23:0] rgb;
    logic        br;
    logic        e_pr;
    logic        e_bv;
    logic [7:0]  e_bd;
    logic        e_last;
    logic        e_fd;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic pv, input logic [23:0] rgb,
                              input logic br, input logic e_pr, input logic e_bv,
                              input logic [7:0] e_bd, input logic e_last, input logic e_fd,
                              input int e_cnt);
    vec_t v;
    v.rn = rn; v.pv = pv; v.rgb = rgb; v.br = br;
    v.e_pr = e_pr; v.e_bv = e_bv; v.e_bd = e_bd; v.e_last = e_last; v.e_fd = e_fd;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [23:0] px[8];
    int k, run, b0, p0;
    bit seen;
    bit prod_done;

    rst_n = 1'b0; pix_valid = 1'b0; byte_ready = 1'b1;
    r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;
    tick(); tick();
    mon_en = 1;

    //  rn pv rgb         br  pr bv bd     last fd cnt
    vecs[0]  = mk(0, 0, 24'h000000, 1, 0, 0, 8'h00, 0, 0, 0);
    vecs[1]  = mk(1, 1, 24'hFF8000, 1, 1, 0, 8'h00, 0, 0, 0);
    vecs[2]  = mk(1, 0, 24'h000000, 1, 1, 1, 8'hFF, 0, 0, 0);
    vecs[3]  = mk(1, 0, 24'h000000, 1, 1, 1, 8'h80, 0, 0, 0);
    vecs[4]  = mk(1, 0, 24'h000000, 1, 1, 1, 8'h00, 0, 0, 0);
    vecs[5]  = mk(1, 0, 24'h000000, 1, 1, 0, 8'h00, 0, 0, 1);
    vecs[6]  = mk(1, 1, 24'h123456, 1, 1, 0, 8'h00, 0, 0, 1);
    vecs[7]  = mk(1, 1, 24'hABCDEF, 1, 1, 1, 8'h12, 0, 0, 1);
    vecs[8]  = mk(1, 0, 24'h000000, 1, 1, 1, 8'h34, 0, 0, 1);
    vecs[9]  = mk(1, 0, 24'h000000, 1, 1, 1, 8'h56, 0, 0, 1);
    vecs[10] = mk(1, 0, 24'h000000, 1, 1, 1, 8'hAB, 0, 0, 2);
    vecs[11] = mk(1, 0, 24'h000000, 1, 1, 1, 8'hCD, 0, 0, 2);
    vecs[12] = mk(1, 0, 24'h000000, 1, 1, 1, 8'hEF, 1, 0, 2);
    vecs[13] = mk(1, 0, 24'h000000, 0, 1, 1, 8'hEF, 1, 0, 2);
    vecs[14] = mk(1, 0, 24'h000000, 0, 1, 1, 8'hEF, 1, 0, 2);
    vecs[15] = mk(1, 0, 24'h000000, 1, 1, 0, 8'h00, 0, 1, 0);
    vecs[16] = mk(1, 0, 24'h000000, 1, 1, 0, 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rn; pix_valid = vecs[i].pv; byte_ready = vecs[i].br;
      {r_in, g_in, b_in} = vecs[i].rgb;
      tick();
      chk($sformatf("vec%0d_pix_ready", i), 32'(pix_ready), 32'(vecs[i].e_pr));
      chk($sformatf("vec%0d_byte_valid", i), 32'(byte_valid), 32'(vecs[i].e_bv));
      chk($sformatf("vec%0d_byte_data", i), 32'(byte_data), 32'(vecs[i].e_bd));
      chk($sformatf("vec%0d_byte_last", i), 32'(byte_last), 32'(vecs[i].e_last));
      chk($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].e_fd));
      chk($sformatf("vec%0d_pix_count", i), 32'(pix_count), 32'(vecs[i].e_cnt));
    end
    pix_valid = 1'b0;

    // Backpressure: FIFO (4) plus hold register absorb 5 pixels, then pix_ready drops.
    for (int i = 0; i < 8; i++) px[i] = {8'(i + 1), 8'(i + 8'h40), 8'(i + 8'h80)};
    byte_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      logic acc;
      pix_valid = 1'b1;
      {r_in, g_in, b_in} = px[k];
      acc = pix_ready;
      tick();
      if (acc) k++;
    end
    pix_valid = 1'b0;
    chk("bp_accepted", 32'(k), 32'd5);
    chk("bp_pix_ready", 32'(pix_ready), 32'd0);
    chk("bp_hold_byte", 32'(byte_data), 32'(px[0][23:16]));
    byte_ready = 1'b1;
    for (int i = 5; i < 8; i++) send_pixel(px[i]);
    drain();

    // Streaming: 16 pixels must leave as 48 back-to-back bytes.
    b0 = bytes_acc;
    run = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send_pixel({8'(i), 8'(~i), 8'(i * 7)});
      end
      begin
        seen = 0;
        for (int t = 0; t < 20; t++) begin
          if (byte_valid) begin
            seen = 1;
            break;
          end
          tick();
        end
        chk("stream_start", 32'(seen), 32'd1);
        for (int c = 0; c < 48; c++) begin
          if (byte_valid) run++;
          tick();
        end
        chk("stream_run", 32'(run), 32'd48);
        chk("stream_tail_valid", 32'(byte_valid), 32'd0);
      end
    join
    drain();
    chk("stream_bytes", 32'(bytes_acc - b0), 32'd48);

    // Reset in the middle of a pixel: partial pixel dropped, counter back to zero.
    send_pixel(24'hC0FFEE);
    send_pixel(24'h112233);
    tick();
    chk("mid_byte_g", 32'(byte_data), 32'hFF);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_byte_valid", 32'(byte_valid), 32'd0);
      chk("rst_pix_count", 32'(pix_count), 32'd0);
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_rst_pix_ready", 32'(pix_ready), 32'd1);
    chk("post_rst_byte_valid", 32'(byte_valid), 32'd0);

    // Frame boundary: 4 pixels with a 3-pixel frame.
    bytes_acc = 0; last_cnt = 0; last_at = 0; fd_pulses = 0;
    cnt_log.delete();
    for (int i = 0; i < 4; i++) send_pixel({8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)});
    drain();
    tick();
    chk("frame_bytes", 32'(bytes_acc), 32'd12);
    chk("frame_last_count", 32'(last_cnt), 32'd1);
    chk("frame_last_index", 32'(last_at), 32'd9);
    chk("frame_done_pulses", 32'(fd_pulses), 32'd1);
    chk("frame_log_len", 32'(cnt_log.size()), 32'd4);
    if (cnt_log.size() == 4) begin
      chk("frame_cnt0", 32'(cnt_log[0]), 32'd0);
      chk("frame_cnt1", 32'(cnt_log[1]), 32'd1);
      chk("frame_cnt2", 32'(cnt_log[2]), 32'd2);
      chk("frame_cnt3", 32'(cnt_log[3]), 32'd0);
    end
    chk("frame_cnt_end", 32'(pix_count), 32'd1);

    // Random valid/ready traffic against the queue model.
    b0 = bytes_acc;
    p0 = pix_acc;
    cnt_log.delete();
    prod_done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(3) == 0) tick();
          send_pixel(24'($urandom));
        end
        prod_done = 1;
      end
      begin
        while (!prod_done) begin
          byte_ready = ($urandom_range(3) != 0);
          tick();
        end
        byte_ready = 1'b1;
      end
    join
    drain();
    chk("rand_pixels", 32'(pix_acc - p0), 32'd10000);
    chk("rand_bytes", 32'(bytes_acc - b0), 32'd30000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
